// File: rtl/mc_controller_if.sv
// mc_controller_if: decoded-instruction inputs and per-step control outputs between sequencer and datapath.
// Latency: pure wiring, no storage.
// Backpressure: mem_ack completes the dm_req handshake; the sequencer holds MEM until it arrives.
interface mc_controller_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ack;
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        ir_we;
    logic        grf_we;
    logic [1:0]  a3_sel;
    logic [1:0]  wd_sel;
    logic        ext_type;
    logic        alu_b_sel;
    logic [5:0]  alu_sel;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    modport master (
        input  opcode, funct, zero, mem_ack,
        output pc_we, npc_sel, ir_we, grf_we, a3_sel, wd_sel, ext_type, alu_b_sel,
               alu_sel, dm_req, dm_we, state, illegal, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ack,
        input  pc_we, npc_sel, ir_we, grf_we, a3_sel, wd_sel, ext_type, alu_b_sel,
               alu_sel, dm_req, dm_we, state, illegal, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; MC_PERF_CNT_EN adds cycle/instr counters.
// Latency: controls are combinational from state_q + opcode/funct; 2..5 cycles per instruction plus DM wait.
// Backpressure: MEM holds dm_req and all ALU controls stable until mem_ack; reset drops the request at once.
module mc_controller (
    input  logic            clk,
    input  logic            reset,
    mc_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_SUB = 6'd1;
    localparam logic [5:0] ALU_OR  = 6'd2;
    localparam logic [5:0] ALU_LUI = 6'd3;

    state_t state_q, state_d;

    logic is_rtype, is_add, is_sub, is_nop, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_legal;

    assign is_rtype = (bus.opcode == 6'h00);
    assign is_add   = is_rtype && (bus.funct == 6'h20);
    assign is_sub   = is_rtype && (bus.funct == 6'h22);
    assign is_jr    = is_rtype && (bus.funct == 6'h08);
    assign is_nop   = is_rtype && (bus.funct == 6'h00);
    assign is_ori   = (bus.opcode == 6'h0D);
    assign is_lui   = (bus.opcode == 6'h0F);
    assign is_lw    = (bus.opcode == 6'h23);
    assign is_sw    = (bus.opcode == 6'h2B);
    assign is_beq   = (bus.opcode == 6'h04);
    assign is_jal   = (bus.opcode == 6'h03);
    assign is_legal = is_add | is_sub | is_jr | is_nop | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_jal;

    logic       pc_we, ir_we, grf_we, ext_type, alu_b_sel, dm_req, dm_we, illegal;
    logic [1:0] npc_sel, a3_sel, wd_sel;
    logic [5:0] alu_sel;

    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        npc_sel   = 2'd0;
        ir_we     = 1'b0;
        grf_we    = 1'b0;
        a3_sel    = 2'd0;
        wd_sel    = 2'd0;
        ext_type  = 1'b0;
        alu_b_sel = 1'b0;
        alu_sel   = ALU_ADD;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop) begin
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_add || is_sub) begin
                    alu_sel = is_sub ? ALU_SUB : ALU_ADD;
                    state_d = S_WB;
                end else if (is_ori) begin
                    alu_b_sel = 1'b1;
                    alu_sel   = ALU_OR;
                    state_d   = S_WB;
                end else if (is_lui) begin
                    alu_b_sel = 1'b1;
                    alu_sel   = ALU_LUI;
                    state_d   = S_WB;
                end else if (is_lw || is_sw) begin
                    ext_type  = 1'b1;
                    alu_b_sel = 1'b1;
                    state_d   = S_MEM;
                end else if (is_beq) begin
                    alu_sel = ALU_SUB;
                    pc_we   = bus.zero;
                    npc_sel = 2'd1;
                end else if (is_jr) begin
                    pc_we   = 1'b1;
                    npc_sel = 2'd3;
                end
            end
            S_MEM: begin
                // Address path stays driven exactly as in EXEC for the whole request.
                ext_type  = 1'b1;
                alu_b_sel = 1'b1;
                dm_req    = 1'b1;
                dm_we     = is_sw;
                if (bus.mem_ack) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                grf_we  = 1'b1;
                state_d = S_FETCH;
                if (is_add || is_sub) begin
                    a3_sel = 2'd1;
                end else if (is_lw) begin
                    wd_sel = 2'd1;
                end else if (is_jal) begin
                    a3_sel  = 2'd2;
                    wd_sel  = 2'd2;
                    pc_we   = 1'b1;
                    npc_sel = 2'd2;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (!reset) begin
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            grf_we  = 1'b0;
            dm_req  = 1'b0;
            dm_we   = 1'b0;
            illegal = 1'b0;
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.pc_we     = pc_we;
    assign bus.npc_sel   = npc_sel;
    assign bus.ir_we     = ir_we;
    assign bus.grf_we    = grf_we;
    assign bus.a3_sel    = a3_sel;
    assign bus.wd_sel    = wd_sel;
    assign bus.ext_type  = ext_type;
    assign bus.alu_b_sel = alu_b_sel;
    assign bus.alu_sel   = alu_sel;
    assign bus.dm_req    = dm_req;
    assign bus.dm_we     = dm_we;
    assign bus.state     = state_q;
    assign bus.illegal   = illegal;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    // An instruction retires whenever the sequencer returns to FETCH.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q;
        if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`else
    assign bus.cycle_cnt = 32'd0;
    assign bus.instr_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plan plus random instruction mix against a step-list reference model.
// Latency: checks every cycle at negedge; inputs change 1 time unit after posedge.
// Backpressure: random mem_ack delays in MEM, stray acks elsewhere, reset during a MEM wait.
module tb_mc_controller;
    localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_ORI = 3, K_LUI = 4, K_LW = 5;
    localparam int K_SW = 6, K_BEQ = 7, K_JR = 8, K_JAL = 9, K_ILL = 10;
    localparam int ST_F = 0, ST_D = 1, ST_E = 2, ST_M = 3, ST_W = 4;
`ifdef MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int exp_cyc;
    int exp_ins;
    logic [5:0] cur_op, cur_fn;
    logic [5:0] ill_op, ill_fn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                                return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h08) || (fn == 6'h00);
            6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    task automatic pick_illegal();
        ill_op = 6'h3F;
        ill_fn = 6'($urandom);
        for (int i = 0; i < 100; i++) begin
            ill_op = (($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom));
            ill_fn = 6'($urandom);
            if (!is_legal(ill_op, ill_fn)) break;
        end
        if (is_legal(ill_op, ill_fn)) ill_op = 6'h3F;
    endtask

    // Instruction word fields seen by the sequencer; funct is immediate bits for I/J types.
    task automatic encode(input int kind);
        cur_fn = 6'($urandom);
        case (kind)
            K_NOP: begin cur_op = 6'h00; cur_fn = 6'h00; end
            K_ADD: begin cur_op = 6'h00; cur_fn = 6'h20; end
            K_SUB: begin cur_op = 6'h00; cur_fn = 6'h22; end
            K_JR:  begin cur_op = 6'h00; cur_fn = 6'h08; end
            K_ORI: cur_op = 6'h0D;
            K_LUI: cur_op = 6'h0F;
            K_LW:  cur_op = 6'h23;
            K_SW:  cur_op = 6'h2B;
            K_BEQ: cur_op = 6'h04;
            K_JAL: cur_op = 6'h03;
            default: begin cur_op = ill_op; cur_fn = ill_fn; end
        endcase
    endtask

    // Expected output word from the per-step control table; unlisted outputs are 0.
    function automatic logic [22:0] model_out(input int kind, input int st, input bit z);
        logic       pc_we, ir_we, grf_we, ext, bsel, req, we, ill;
        logic [1:0] npc, a3, wd;
        logic [5:0] alu;
        {pc_we, ir_we, grf_we, ext, bsel, req, we, ill} = '0;
        {npc, a3, wd} = '0;
        alu = 6'd0;
        case (st)
            ST_F: begin ir_we = 1'b1; pc_we = 1'b1; end
            ST_D: ill = (kind == K_ILL);
            ST_E: case (kind)
                K_SUB:       alu = 6'd1;
                K_ORI:       begin bsel = 1'b1; alu = 6'd2; end
                K_LUI:       begin bsel = 1'b1; alu = 6'd3; end
                K_LW, K_SW:  begin ext = 1'b1; bsel = 1'b1; end
                K_BEQ:       begin alu = 6'd1; pc_we = z; npc = 2'd1; end
                K_JR:        begin pc_we = 1'b1; npc = 2'd3; end
                default:     ;
            endcase
            ST_M: begin req = 1'b1; we = (kind == K_SW); ext = 1'b1; bsel = 1'b1; end
            default: begin
                grf_we = 1'b1;
                case (kind)
                    K_ADD, K_SUB: a3 = 2'd1;
                    K_LW:         wd = 2'd1;
                    K_JAL:        begin a3 = 2'd2; wd = 2'd2; pc_we = 1'b1; npc = 2'd2; end
                    default:      ;
                endcase
            end
        endcase
        return {pc_we, npc, ir_we, grf_we, a3, wd, ext, bsel, alu, req, we, 3'(st), ill};
    endfunction

    function automatic logic [22:0] dut_out();
        return {bus.pc_we, bus.npc_sel, bus.ir_we, bus.grf_we, bus.a3_sel, bus.wd_sel,
                bus.ext_type, bus.alu_b_sel, bus.alu_sel, bus.dm_req, bus.dm_we,
                bus.state, bus.illegal};
    endfunction

    task automatic step(input int kind, input int st, input bit z, input bit ack, input bit last);
        if (st == ST_F) begin
            bus.opcode = 6'($urandom);
            bus.funct  = 6'($urandom);
        end else begin
            bus.opcode = cur_op;
            bus.funct  = cur_fn;
        end
        bus.zero    = z;
        bus.mem_ack = ack;
        @(negedge clk);
        check($sformatf("ctl k%0d s%0d", kind, st), {9'd0, dut_out()}, {9'd0, model_out(kind, st, z)});
        check("cycle_cnt", bus.cycle_cnt, PERF ? 32'(exp_cyc) : 32'd0);
        check("instr_cnt", bus.instr_cnt, PERF ? 32'(exp_ins) : 32'd0);
        @(posedge clk);
        #1;
        exp_cyc++;
        if (last) exp_ins++;
    endtask

    // Step list follows the per-instruction cycle budget; w = cycles waiting for mem_ack.
    task automatic run_instr(input int kind, input int w, input int zsel);
        int seq[$];
        int m_idx;
        bit z;
        bit ack;
        encode(kind);
        z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        seq = '{ST_F, ST_D};
        case (kind)
            K_NOP, K_ILL:               ;
            K_BEQ, K_JR:                seq.push_back(ST_E);
            K_JAL:                      seq.push_back(ST_W);
            K_ADD, K_SUB, K_ORI, K_LUI: begin seq.push_back(ST_E); seq.push_back(ST_W); end
            default: begin
                seq.push_back(ST_E);
                for (int i = 0; i <= w; i++) seq.push_back(ST_M);
                if (kind == K_LW) seq.push_back(ST_W);
            end
        endcase
        m_idx = 0;
        foreach (seq[i]) begin
            if (seq[i] == ST_M) begin
                ack = (m_idx == w);
                m_idx++;
            end else begin
                ack = 1'($urandom);
            end
            step(kind, seq[i], z, ack, i == seq.size() - 1);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_enables", {26'd0, bus.pc_we, bus.ir_we, bus.grf_we, bus.dm_req, bus.dm_we, bus.illegal}, 32'd0);
            if (i > 0) begin
                check("rst_state", {29'd0, bus.state}, 32'd0);
                check("rst_cycle_cnt", bus.cycle_cnt, 32'd0);
                check("rst_instr_cnt", bus.instr_cnt, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        reset   = 1'b1;
        exp_cyc = 0;
        exp_ins = 0;
    endtask

    initial begin
        int kind;
        n_chk   = 0;
        n_fail  = 0;
        exp_cyc = 0;
        exp_ins = 0;
        bus.opcode  = 6'h00;
        bus.funct   = 6'h00;
        bus.zero    = 1'b0;
        bus.mem_ack = 1'b0;
        reset       = 1'b0;
        ill_op      = 6'h3F;
        ill_fn      = 6'h00;

        do_reset(3);

        run_instr(K_ORI, 0, -1);
        run_instr(K_ADD, 0, -1);
        run_instr(K_SW, 3, -1);
        run_instr(K_LW, 0, -1);
        run_instr(K_BEQ, 0, 1);
        run_instr(K_BEQ, 0, 0);
        do_reset(2);
        run_instr(K_JAL, 0, -1);
        run_instr(K_JR, 0, -1);
        @(negedge clk);
        check("instr_cnt_jal_jr", bus.instr_cnt, PERF ? 32'd2 : 32'd0);
        @(posedge clk);
        #1;
        exp_cyc++;
        // The extra idle FETCH cycle above belongs to the following instruction's FETCH slot.
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        @(negedge clk);
        @(posedge clk);
        #1;
        exp_cyc++;
        do_reset(1);
        run_instr(K_NOP, 0, -1);
        ill_op = 6'h3F;
        ill_fn = 6'h00;
        run_instr(K_ILL, 0, -1);
        run_instr(K_SUB, 0, -1);
        run_instr(K_LUI, 0, -1);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 10);
            if (kind == K_ILL) pick_illegal();
            run_instr(kind, (kind == K_LW || kind == K_SW) ? $urandom_range(0, 4) : 0, -1);
        end

        // Reset during a MEM wait: request drops in the same cycle, late ack ignored.
        encode(K_SW);
        step(K_SW, ST_F, 1'b0, 1'b0, 1'b0);
        step(K_SW, ST_D, 1'b0, 1'b0, 1'b0);
        step(K_SW, ST_E, 1'b0, 1'b0, 1'b0);
        step(K_SW, ST_M, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("mid_mem_dm_req", {31'd0, bus.dm_req}, 32'd0);
        check("mid_mem_dm_we", {31'd0, bus.dm_we}, 32'd0);
        check("mid_mem_state", {29'd0, bus.state}, 32'd3);
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("post_rst_state", {29'd0, bus.state}, 32'd0);
        check("post_rst_dm_req", {31'd0, bus.dm_req}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        exp_cyc = 0;
        exp_ins = 0;
        run_instr(K_LW, 1, -1);
        run_instr(K_ORI, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
